// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit packet path.
package usb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    CRC_LO,
    CRC_HI,
    ABORT,
    EOP,
    IDLE_J
  } state_t;

  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam logic [3:0]  PID_ACK      = 4'h2;
  localparam logic [3:0]  PID_NAK      = 4'hA;
  localparam logic [3:0]  PID_DATA0    = 4'h3;
  localparam logic [3:0]  PID_DATA1    = 4'hB;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  // Reflected CRC16 step over one byte, data bits consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY_R;
      else                c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Running CRC16 register over payload bytes; one byte per en, restarted by clear.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     crc <= CRC16_INIT;
    else if (clear) crc <= CRC16_INIT;
    else if (en)    crc <= crc16_byte(crc, byte_in);
  end

endmodule

// File: rtl/usb_tx_packet_ctrl.sv
// USB transmit packet sequencer: SYNC, PID, payload and CRC16 byte slots followed by EOP.
// Payload handshake (byte_ready) falls on the last cycle before a DATA slot so the byte loads at count 0.
module usb_tx_packet_ctrl
  import usb_pkg::*;
#(
  parameter int BIT_CLKS  = 8,
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       load_enable,
  output logic [7:0] shift_data,
  output logic       eop,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int            SLOT_CLKS = 8 * BIT_CLKS;
  localparam int            CW        = $clog2(SLOT_CLKS);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CLKS - 1);
  localparam logic [CW-1:0] SLOT_PRE  = CW'(SLOT_CLKS - 2);
  localparam logic [CW-1:0] EOP_LAST  = CW'(2 * BIT_CLKS - 1);
  localparam logic [CW-1:0] J_LAST    = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] J_PRE     = CW'(BIT_CLKS - 2);
  localparam logic [6:0]    BYTES_MAX = 7'(MAX_BYTES);
  localparam logic [6:0]    BYTES_SAT = 7'(MAX_BYTES + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    byte_cnt;
  logic [3:0]    pid_q;
  logic          last_q;
  logic [15:0]   crc;
  logic          crc_clear;
  logic          crc_en;
  logic          more_data;

  assign crc_clear = (state == IDLE) && tx_start;
  assign crc_en    = byte_ready && byte_valid;
  assign more_data = ((state == PID) && is_data_pid(pid_q)) ||
                     ((state == DATA) && !last_q && (byte_cnt != BYTES_MAX));

  usb_crc16 u_crc (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (crc_clear),
    .en      (crc_en),
    .byte_in (byte_data),
    .crc     (crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      byte_cnt    <= '0;
      pid_q       <= '0;
      last_q      <= 1'b0;
      byte_ready  <= 1'b0;
      load_enable <= 1'b0;
      shift_data  <= 8'h00;
      eop         <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      load_enable <= 1'b0;
      byte_ready  <= 1'b0;
      tx_error    <= 1'b0;
      tx_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            state       <= SYNC;
            cnt         <= '0;
            pid_q       <= tx_pid;
            byte_cnt    <= '0;
            last_q      <= 1'b0;
            load_enable <= 1'b1;
            shift_data  <= SYNC_BYTE;
            tx_busy     <= 1'b1;
          end
        end
        SYNC, PID, DATA, CRC_LO, CRC_HI: begin
          if (cnt != SLOT_LAST) begin
            cnt <= cnt + 1'b1;
            if ((cnt == SLOT_PRE) && more_data) byte_ready <= 1'b1;
          end else begin
            cnt <= '0;
            case (state)
              SYNC: begin
                state       <= PID;
                load_enable <= 1'b1;
                shift_data  <= {~pid_q, pid_q};
              end
              PID, DATA: begin
                if ((state == PID) && !is_data_pid(pid_q)) begin
                  state <= EOP;
                  eop   <= 1'b1;
                end else if ((state == DATA) && last_q) begin
                  state       <= CRC_LO;
                  load_enable <= 1'b1;
                  shift_data  <= ~crc[7:0];
                end else if (byte_ready && byte_valid) begin
                  state       <= DATA;
                  load_enable <= 1'b1;
                  shift_data  <= byte_data;
                  byte_cnt    <= byte_cnt + 7'd1;
                  last_q      <= byte_last;
                end else if ((state == PID) && byte_last) begin
                  // Empty DATA packet: go straight to the CRC of no bytes.
                  state       <= CRC_LO;
                  load_enable <= 1'b1;
                  shift_data  <= ~crc[7:0];
                end else begin
                  state    <= ABORT;
                  tx_error <= 1'b1;
                  if (byte_cnt == BYTES_MAX) byte_cnt <= BYTES_SAT;
                end
              end
              CRC_LO: begin
                state       <= CRC_HI;
                load_enable <= 1'b1;
                shift_data  <= ~crc[15:8];
              end
              default: begin
                state <= EOP;
                eop   <= 1'b1;
              end
            endcase
          end
        end
        ABORT: begin
          state <= EOP;
          cnt   <= '0;
          eop   <= 1'b1;
        end
        EOP: begin
          if (cnt == EOP_LAST) begin
            state <= IDLE_J;
            cnt   <= '0;
            eop   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_J: begin
          if (cnt == J_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            tx_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == J_PRE) tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
